// File: rtl/mrv32_lsu_mem.sv
// -----------------------------------------------------------------------------
// mrv32_lsu_mem -- MRV32 data-memory subsystem.
//
// The load/store unit (mrv32_lsu) sits in front of a byte-addressed dual-port
// RAM (dual_port_byte_mem). Port B of the RAM belongs to the LSU. Port A is
// exported for the fetch side.
//
// Contents of this file, in dependency order:
//   mrv32_pkg           store size codes, load funct3 codes, LSU state type
//   dual_port_byte_mem  two word-wide ports with byte strobes, RD_LATENCY 1 or 2
//   mrv32_lsu           request classification, lane steering, load extension
//   mrv32_lsu_mem       top level: LSU + RAM
//
// Top-level ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_valid/mem_ren/mem_wen      request strobe and load/store select
//   mem_wstrb[3:0]                 store size code (WSTRB_B/H/W)
//   load_funct3[2:0]               load type (LB/LH/LW/LBU/LHU)
//   eff_addr[31:0]                 byte address of the access
//   store_data[31:0]               right-justified store data
//   lsu_done                       one-cycle completion pulse
//   load_data[31:0]                extended load result
//   a_valid/a_addr/a_wdata/a_wstrb RAM port A request
//   a_rdata[31:0], a_rvalid        RAM port A response
// -----------------------------------------------------------------------------

package mrv32_pkg;
  // Store size codes, right-justified; the LSU shifts them into the lane.
  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  // Load funct3 codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT,
    LSU_DONE,
    LSU_HOLD
  } lsu_state_e;
endpackage

// -----------------------------------------------------------------------------
// dual_port_byte_mem -- byte-organised RAM with two identical word ports.
//   Each port: valid, addr (low two bits ignored), wdata, wstrb in;
//   rdata, rvalid out. Every accepted access returns the addressed word
//   RD_LATENCY cycles later with a one-cycle rvalid pulse.
//   Cross-port read-during-write returns old data; on a cross-port write
//   collision to the same byte, port B wins.
// -----------------------------------------------------------------------------
module dual_port_byte_mem #(
  parameter int MEM_BYTES   = 16384,
  parameter int ADDR_WIDTH  = $clog2(MEM_BYTES),
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  input  logic [3:0]            a_wstrb,
  output logic [31:0]           a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_wdata,
  input  logic [3:0]            b_wstrb,
  output logic [31:0]           b_rdata,
  output logic                  b_rvalid
);

  logic [7:0] mem [0:MEM_BYTES-1];

  // Word-aligned base addresses; the low two address bits are dropped.
  logic [ADDR_WIDTH-1:0] a_base;
  logic [ADDR_WIDTH-1:0] b_base;
  assign a_base = a_addr & ~ADDR_WIDTH'(3);
  assign b_base = b_addr & ~ADDR_WIDTH'(3);

  // Word each access returns. With WRITE_FIRST the port's own write lanes
  // bypass the array so a read-during-write sees the new bytes; the other
  // port's write is never forwarded, so cross-port reads see old data.
  logic [31:0] a_word;
  logic [31:0] b_word;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here, unconditionally in the loop) so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_word[8*i +: 8] = mem[a_base + ADDR_WIDTH'(i)];
      b_word[8*i +: 8] = mem[b_base + ADDR_WIDTH'(i)];
      if (WRITE_FIRST != 0 && a_wstrb[i]) a_word[8*i +: 8] = a_wdata[8*i +: 8];
      if (WRITE_FIRST != 0 && b_wstrb[i]) b_word[8*i +: 8] = b_wdata[8*i +: 8];
    end
  end

  // NOTE: the storage array has no reset branch; clearing thousands of bytes
  // in one cycle is not something real RAM macros can do, and software never
  // relies on RAM contents after reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_valid && a_wstrb[i]) mem[a_base + ADDR_WIDTH'(i)] <= a_wdata[8*i +: 8];
      // Port B is written second, so it overrides port A on the same byte.
      if (b_valid && b_wstrb[i]) mem[b_base + ADDR_WIDTH'(i)] <= b_wdata[8*i +: 8];
    end
  end

  // First read stage: present for both supported latencies.
  logic        a_rvalid_q1;
  logic        b_rvalid_q1;
  logic [31:0] a_rdata_q1;
  logic [31:0] b_rdata_q1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q1 <= 1'b0;
      b_rvalid_q1 <= 1'b0;
      a_rdata_q1  <= '0;
      b_rdata_q1  <= '0;
    end else begin
      a_rvalid_q1 <= a_valid;
      b_rvalid_q1 <= b_valid;
      if (a_valid) a_rdata_q1 <= a_word;
      if (b_valid) b_rdata_q1 <= b_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic        a_rvalid_q2;
      logic        b_rvalid_q2;
      logic [31:0] a_rdata_q2;
      logic [31:0] b_rdata_q2;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rvalid_q2 <= 1'b0;
          b_rvalid_q2 <= 1'b0;
          a_rdata_q2  <= '0;
          b_rdata_q2  <= '0;
        end else begin
          a_rvalid_q2 <= a_rvalid_q1;
          b_rvalid_q2 <= b_rvalid_q1;
          if (a_rvalid_q1) a_rdata_q2 <= a_rdata_q1;
          if (b_rvalid_q1) b_rdata_q2 <= b_rdata_q1;
        end
      end

      assign a_rvalid = a_rvalid_q2;
      assign b_rvalid = b_rvalid_q2;
      assign a_rdata  = a_rdata_q2;
      assign b_rdata  = b_rdata_q2;
    end else begin : g_lat1
      assign a_rvalid = a_rvalid_q1;
      assign b_rvalid = b_rvalid_q1;
      assign a_rdata  = a_rdata_q1;
      assign b_rdata  = b_rdata_q1;
    end
  endgenerate

endmodule

// -----------------------------------------------------------------------------
// mrv32_lsu -- load/store unit driving RAM port B.
//   Request side: mem_valid, mem_ren, mem_wen, mem_wstrb, load_funct3,
//   eff_addr, store_data in; lsu_done, load_data out.
//   RAM side: b_valid, b_addr, b_wdata, b_wstrb out; b_rdata, b_rvalid in.
//   Illegal requests (bad op mix, out of range, misaligned, bad code) never
//   touch the RAM, clear load_data and still complete with lsu_done.
// -----------------------------------------------------------------------------
module mrv32_lsu
  import mrv32_pkg::*;
#(
  parameter int MEM_BYTES  = 16384,
  parameter int ADDR_WIDTH = $clog2(MEM_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [3:0]            mem_wstrb,
  input  logic [2:0]            load_funct3,
  input  logic [31:0]           eff_addr,
  input  logic [31:0]           store_data,
  output logic                  lsu_done,
  output logic [31:0]           load_data,
  output logic                  b_valid,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [31:0]           b_wdata,
  output logic [3:0]            b_wstrb,
  input  logic [31:0]           b_rdata,
  input  logic                  b_rvalid
);

  lsu_state_e  state_q;
  logic        lsu_done_q;
  logic [31:0] load_data_q;

  // ---- request classification --------------------------------------------
  logic       is_load;
  logic       is_store;
  logic       in_range;
  logic       code_ok;
  logic       aligned;
  logic       legal;
  logic [1:0] size_log2;  // 0 byte, 1 halfword, 2 word

  assign is_load  = mem_ren & ~mem_wen;
  assign is_store = mem_wen & ~mem_ren;
  assign in_range = eff_addr < 32'(MEM_BYTES);

  always_comb begin
    size_log2 = 2'd0;
    code_ok   = 1'b0;
    if (is_load) begin
      case (load_funct3)
        F3_LB, F3_LBU: begin size_log2 = 2'd0; code_ok = 1'b1; end
        F3_LH, F3_LHU: begin size_log2 = 2'd1; code_ok = 1'b1; end
        F3_LW:         begin size_log2 = 2'd2; code_ok = 1'b1; end
        default:       code_ok = 1'b0;
      endcase
    end else if (is_store) begin
      case (mem_wstrb)
        WSTRB_B: begin size_log2 = 2'd0; code_ok = 1'b1; end
        WSTRB_H: begin size_log2 = 2'd1; code_ok = 1'b1; end
        WSTRB_W: begin size_log2 = 2'd2; code_ok = 1'b1; end
        default: code_ok = 1'b0;
      endcase
    end

    case (size_log2)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~eff_addr[0];
      default: aligned = (eff_addr[1:0] == 2'b00);
    endcase

    legal = (is_load | is_store) & in_range & code_ok & aligned;
  end

  // ---- port B drive ---------------------------------------------------------
  // The access is issued combinationally in IDLE so a store commits on the
  // same edge that accepts the request. Alignment guarantees the shifted
  // strobe stays inside the word.
  always_comb begin
    b_valid = 1'b0;
    b_addr  = eff_addr[ADDR_WIDTH-1:0];
    b_wstrb = WSTRB_NONE;
    b_wdata = '0;
    if (state_q == LSU_IDLE && mem_valid && legal) begin
      b_valid = 1'b1;
      if (is_store) begin
        b_wstrb = mem_wstrb << eff_addr[1:0];
        b_wdata = store_data << {eff_addr[1:0], 3'b000};
      end
    end
  end

  // ---- load extension -------------------------------------------------------
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  funct3);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (funct3)
      F3_LB:   extend_load = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  extend_load = {24'h0, shifted[7:0]};
      F3_LH:   extend_load = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  extend_load = {16'h0, shifted[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  // ---- control FSM ----------------------------------------------------------
  // lsu_done is registered on entry to DONE, so it is high exactly while the
  // machine sits in DONE. HOLD swallows one cycle so a request still held
  // after done is not accepted a second time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      lsu_done_q  <= 1'b0;
      load_data_q <= '0;
    end else begin
      lsu_done_q <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (mem_valid) begin
            if (!legal) begin
              load_data_q <= '0;
              lsu_done_q  <= 1'b1;
              state_q     <= LSU_DONE;
            end else if (is_load) begin
              state_q <= LSU_WAIT;
            end else begin
              lsu_done_q <= 1'b1;
              state_q    <= LSU_DONE;
            end
          end
        end
        LSU_WAIT: begin
          if (b_rvalid) begin
            load_data_q <= extend_load(b_rdata, eff_addr[1:0], load_funct3);
            lsu_done_q  <= 1'b1;
            state_q     <= LSU_DONE;
          end
        end
        LSU_DONE: state_q <= LSU_HOLD;
        LSU_HOLD: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

  assign lsu_done  = lsu_done_q;
  assign load_data = load_data_q;

endmodule

// -----------------------------------------------------------------------------
// mrv32_lsu_mem -- top level; see file header for the port summary.
// -----------------------------------------------------------------------------
module mrv32_lsu_mem #(
  parameter int MEM_BYTES   = 16384,
  parameter int ADDR_WIDTH  = $clog2(MEM_BYTES),
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [3:0]            mem_wstrb,
  input  logic [2:0]            load_funct3,
  input  logic [31:0]           eff_addr,
  input  logic [31:0]           store_data,
  output logic                  lsu_done,
  output logic [31:0]           load_data,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_wdata,
  input  logic [3:0]            a_wstrb,
  output logic [31:0]           a_rdata,
  output logic                  a_rvalid
);

  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [31:0]           b_wdata;
  logic [3:0]            b_wstrb;
  logic [31:0]           b_rdata;
  logic                  b_rvalid;

  mrv32_lsu #(
    .MEM_BYTES  (MEM_BYTES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lsu (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_wstrb   (mem_wstrb),
    .load_funct3 (load_funct3),
    .eff_addr    (eff_addr),
    .store_data  (store_data),
    .lsu_done    (lsu_done),
    .load_data   (load_data),
    .b_valid     (b_valid),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_wstrb     (b_wstrb),
    .b_rdata     (b_rdata),
    .b_rvalid    (b_rvalid)
  );

  dual_port_byte_mem #(
    .MEM_BYTES   (MEM_BYTES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .RD_LATENCY  (RD_LATENCY),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_wstrb  (a_wstrb),
    .a_rdata  (a_rdata),
    .a_rvalid (a_rvalid),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_wstrb  (b_wstrb),
    .b_rdata  (b_rdata),
    .b_rvalid (b_rvalid)
  );

endmodule

// File: tb/tb_mrv32_lsu_mem.sv
// -----------------------------------------------------------------------------
// tb_mrv32_lsu_mem -- directed bench for the MRV32 data-memory subsystem.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mrv32_lsu_mem;

  localparam int MEM_BYTES = 16384;
  localparam int AW        = $clog2(MEM_BYTES);

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid, mem_ren, mem_wen;
  logic [3:0]    mem_wstrb;
  logic [2:0]    load_funct3;
  logic [31:0]   eff_addr, store_data;
  logic          lsu_done;
  logic [31:0]   load_data;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_wstrb;
  logic [31:0]   a_rdata;
  logic          a_rvalid;

  int n_checks = 0;
  int n_pass   = 0;

  // Scratch results of the most recent issue() call.
  logic [31:0] ld;
  int          lat;
  int          bv;
  logic        da;

  always #5 clk = ~clk;

  mrv32_lsu_mem #(
    .MEM_BYTES   (MEM_BYTES),
    .RD_LATENCY  (1),
    .WRITE_FIRST (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_wstrb   (mem_wstrb),
    .load_funct3 (load_funct3),
    .eff_addr    (eff_addr),
    .store_data  (store_data),
    .lsu_done    (lsu_done),
    .load_data   (load_data),
    .a_valid     (a_valid),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_wstrb     (a_wstrb),
    .a_rdata     (a_rdata),
    .a_rvalid    (a_rvalid)
  );

  function automatic logic [31:0] peek_word(input int addr);
    peek_word = {dut.u_ram.mem[addr+3], dut.u_ram.mem[addr+2],
                 dut.u_ram.mem[addr+1], dut.u_ram.mem[addr]};
  endfunction

  // Drive one request starting in an IDLE cycle. Returns the load result,
  // the number of edges until lsu_done (-1 on timeout), the number of cycles
  // b_valid was seen high (including the DONE and HOLD cycles), and lsu_done
  // as seen in the cycle after the pulse. With hold_after the request stays
  // asserted through HOLD so the next call can replace it in the same timestep.
  task automatic issue(input logic ren, input logic wen, input logic [3:0] ws,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold_after,
                       output logic [31:0] o_ld, output int o_lat,
                       output int o_bv, output logic o_da);
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_wstrb = ws;
    load_funct3 = f3; eff_addr = addr; store_data = data;
    o_lat = -1; o_bv = 0; o_ld = 'x; o_da = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (dut.b_valid === 1'b1) o_bv++;
      @(negedge clk);
      if (lsu_done === 1'b1) begin
        o_lat = k;
        o_ld  = load_data;
        break;
      end
    end
    if (!hold_after) mem_valid = 1'b0;
    #1;
    if (dut.b_valid === 1'b1) o_bv++;
    @(negedge clk);
    o_da = lsu_done;
    #1;
    if (dut.b_valid === 1'b1) o_bv++;
    if (!hold_after) mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_wstrb = 4'h0;
    load_funct3 = 3'b000; eff_addr = '0; store_data = '0;
    a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (lsu_done !== 1'b0) $display("FAIL reset_done: got %b want 0", lsu_done); else n_pass++;
    n_checks++; if (load_data !== 32'h0) $display("FAIL reset_load_data: got %h want 0", load_data); else n_pass++;
    n_checks++; if (dut.b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b want 0", dut.b_valid); else n_pass++;
    n_checks++; if (a_rvalid !== 1'b0 || dut.b_rvalid !== 1'b0)
      $display("FAIL reset_rvalid: got a=%b b=%b want 0 0", a_rvalid, dut.b_rvalid); else n_pass++;
    n_checks++; if (a_rdata !== 32'h0 || dut.b_rdata !== 32'h0)
      $display("FAIL reset_rdata: got a=%h b=%h want 0 0", a_rdata, dut.b_rdata); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    issue(1'b0, 1'b1, 4'b1111, 3'b000, 32'h100, 32'hA1B2C3D4, 1'b0, ld, lat, bv, da);
    n_checks++; if (lat !== 1) $display("FAIL sw_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (bv !== 1) $display("FAIL sw_b_valid_cycles: got %0d want 1", bv); else n_pass++;
    n_checks++; if (peek_word(32'h100) !== 32'hA1B2C3D4)
      $display("FAIL sw_mem_bytes: got %h want a1b2c3d4", peek_word(32'h100)); else n_pass++;
    n_checks++; if (dut.u_ram.mem[32'h100] !== 8'hD4)
      $display("FAIL sw_mem_lane0: got %h want d4", dut.u_ram.mem[32'h100]); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h100, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (lat !== 2) $display("FAIL lw_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (ld !== 32'hA1B2C3D4) $display("FAIL lw_data: got %h want a1b2c3d4", ld); else n_pass++;
    n_checks++; if (da !== 1'b0) $display("FAIL lw_done_width: got %b want 0", da); else n_pass++;
  endtask

  task automatic test_byte();
    issue(1'b0, 1'b1, 4'b0001, 3'b000, 32'h101, 32'h00000080, 1'b0, ld, lat, bv, da);
    n_checks++; if (peek_word(32'h100) !== 32'hA1B280D4)
      $display("FAIL sb_mem: got %h want a1b280d4", peek_word(32'h100)); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b000, 32'h101, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", ld); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b100, 32'h101, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h00000080) $display("FAIL lbu_data: got %h want 00000080", ld); else n_pass++;
  endtask

  task automatic test_half();
    issue(1'b0, 1'b1, 4'b0011, 3'b000, 32'h102, 32'h00008001, 1'b0, ld, lat, bv, da);
    n_checks++; if (peek_word(32'h100) !== 32'h800180D4)
      $display("FAIL sh_mem: got %h want 800180d4", peek_word(32'h100)); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b001, 32'h102, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'hFFFF8001) $display("FAIL lh_data: got %h want ffff8001", ld); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b101, 32'h102, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h00008001) $display("FAIL lhu_data: got %h want 00008001", ld); else n_pass++;
  endtask

  task automatic test_misaligned();
    // load_data is 0x00008001 from the previous load; it must be cleared.
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h102, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (lat !== 1) $display("FAIL misaligned_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (ld !== 32'h0) $display("FAIL misaligned_data: got %h want 0", ld); else n_pass++;
    n_checks++; if (bv !== 0) $display("FAIL misaligned_b_valid: got %0d want 0", bv); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b001, 32'h101, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (bv !== 0 || lat !== 1)
      $display("FAIL misaligned_lh: got bv=%0d lat=%0d want 0 1", bv, lat); else n_pass++;
  endtask

  task automatic test_range();
    issue(1'b1, 1'b0, 4'b0000, 3'b010, MEM_BYTES + 16, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h0 || bv !== 0)
      $display("FAIL oor_load: got data=%h bv=%0d want 0 0", ld, bv); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h100, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h800180D4) $display("FAIL lw_before_oor_store: got %h want 800180d4", ld); else n_pass++;
    issue(1'b0, 1'b1, 4'b1111, 3'b000, MEM_BYTES + 32, 32'hDEADBEEF, 1'b0, ld, lat, bv, da);
    n_checks++; if (bv !== 0 || lat !== 1)
      $display("FAIL oor_store: got bv=%0d lat=%0d want 0 1", bv, lat); else n_pass++;
    n_checks++; if (ld !== 32'h0) $display("FAIL oor_store_clears: got %h want 0", ld); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h100, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h800180D4) $display("FAIL no_alias_wrap: got %h want 800180d4", ld); else n_pass++;
    // A legal store must leave load_data untouched.
    issue(1'b0, 1'b1, 4'b0001, 3'b000, 32'h200, 32'h00000077, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h800180D4) $display("FAIL store_keeps_load_data: got %h want 800180d4", ld); else n_pass++;
    n_checks++; if (dut.u_ram.mem[32'h200] !== 8'h77)
      $display("FAIL sb_0x200: got %h want 77", dut.u_ram.mem[32'h200]); else n_pass++;
  endtask

  task automatic test_illegal_codes();
    issue(1'b1, 1'b0, 4'b0000, 3'b011, 32'h100, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (bv !== 0 || ld !== 32'h0 || lat !== 1)
      $display("FAIL bad_funct3: got bv=%0d data=%h lat=%0d want 0 0 1", bv, ld, lat); else n_pass++;
    issue(1'b1, 1'b1, 4'b1111, 3'b010, 32'h100, 32'h12345678, 1'b0, ld, lat, bv, da);
    n_checks++; if (bv !== 0 || lat !== 1)
      $display("FAIL ren_and_wen: got bv=%0d lat=%0d want 0 1", bv, lat); else n_pass++;
    issue(1'b0, 1'b1, 4'b0111, 3'b000, 32'h100, 32'h12345678, 1'b0, ld, lat, bv, da);
    n_checks++; if (bv !== 0 || lat !== 1)
      $display("FAIL bad_wstrb: got bv=%0d lat=%0d want 0 1", bv, lat); else n_pass++;
    n_checks++; if (peek_word(32'h100) !== 32'h800180D4)
      $display("FAIL illegal_no_write: got %h want 800180d4", peek_word(32'h100)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 4'b1111, 3'b000, 32'h300, 32'h11223344, 1'b1, ld, lat, bv, da);
    n_checks++; if (bv !== 1 || da !== 1'b0)
      $display("FAIL b2b_store: got bv=%0d done_after=%b want 1 0", bv, da); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h300, 32'h0, 1'b1, ld, lat, bv, da);
    n_checks++; if (bv !== 1 || da !== 1'b0 || lat !== 2)
      $display("FAIL b2b_load_handshake: got bv=%0d done_after=%b lat=%0d want 1 0 2", bv, da, lat); else n_pass++;
    n_checks++; if (ld !== 32'h11223344) $display("FAIL b2b_load_data: got %h want 11223344", ld); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b100, 32'h302, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (bv !== 1 || da !== 1'b0 || ld !== 32'h00000022)
      $display("FAIL b2b_lbu: got bv=%0d done_after=%b data=%h want 1 0 00000022", bv, da, ld); else n_pass++;
  endtask

  task automatic test_port_a();
    @(negedge clk);
    a_valid = 1'b1; a_addr = AW'(32'h400); a_wdata = 32'hCAFEF00D; a_wstrb = 4'hF;
    @(negedge clk);
    a_wstrb = 4'h0;
    n_checks++; if (a_rvalid !== 1'b1) $display("FAIL a_write_rvalid: got %b want 1", a_rvalid); else n_pass++;
    @(negedge clk);
    a_addr = AW'(32'h100);
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hCAFEF00D)
      $display("FAIL a_read_back: got rvalid=%b data=%h want 1 cafef00d", a_rvalid, a_rdata); else n_pass++;
    @(negedge clk);
    a_valid = 1'b0;
    n_checks++; if (a_rdata !== 32'h800180D4)
      $display("FAIL a_reads_lsu_data: got %h want 800180d4", a_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (a_rvalid !== 1'b0) $display("FAIL a_rvalid_pulse: got %b want 0", a_rvalid); else n_pass++;
  endtask

  task automatic test_collision();
    // Port A writes the whole word while the LSU stores one byte to lane 0.
    @(negedge clk);
    a_valid = 1'b1; a_addr = AW'(32'h300); a_wdata = 32'hAAAAAAAA; a_wstrb = 4'hF;
    mem_valid = 1'b1; mem_ren = 1'b0; mem_wen = 1'b1; mem_wstrb = 4'b0001;
    eff_addr = 32'h300; store_data = 32'h00000055;
    #1;
    n_checks++; if (dut.b_valid !== 1'b1) $display("FAIL collide_b_valid: got %b want 1", dut.b_valid); else n_pass++;
    @(negedge clk);
    a_valid = 1'b0; a_wstrb = 4'h0; mem_valid = 1'b0;
    n_checks++; if (lsu_done !== 1'b1) $display("FAIL collide_done: got %b want 1", lsu_done); else n_pass++;
    n_checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h11223344)
      $display("FAIL collide_old_data: got rvalid=%b data=%h want 1 11223344", a_rvalid, a_rdata); else n_pass++;
    n_checks++; if (peek_word(32'h300) !== 32'hAAAAAA55)
      $display("FAIL collide_b_wins: got %h want aaaaaa55", peek_word(32'h300)); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    int done_seen;
    @(negedge clk);
    mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_wstrb = 4'h0;
    load_funct3 = 3'b010; eff_addr = 32'h300;
    @(negedge clk);
    // Machine is in WAIT with the read response in flight.
    rst = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (lsu_done === 1'b1) done_seen++;
      @(negedge clk);
    end
    n_checks++; if (done_seen !== 0) $display("FAIL reset_abandons: got %0d done pulses want 0", done_seen); else n_pass++;
    n_checks++; if (load_data !== 32'h0) $display("FAIL reset_mid_data: got %h want 0", load_data); else n_pass++;
    n_checks++; if (peek_word(32'h300) !== 32'hAAAAAA55)
      $display("FAIL reset_keeps_mem: got %h want aaaaaa55", peek_word(32'h300)); else n_pass++;
    issue(1'b1, 1'b0, 4'b0000, 3'b000, 32'h300, 32'h0, 1'b0, ld, lat, bv, da);
    n_checks++; if (ld !== 32'h00000055 || lat !== 2)
      $display("FAIL post_reset_lb: got data=%h lat=%0d want 00000055 2", ld, lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_range();
    test_illegal_codes();
    test_back_to_back();
    test_port_a();
    test_collision();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrv32_lsu_mem.md
# mrv32_lsu_mem

The block is the MRV32 data-memory subsystem. It combines the load/store unit `mrv32_lsu` with the byte-addressed RAM `dual_port_byte_mem`. Port B of the RAM is private to the LSU. Port A is exported for the fetch side.

The LSU takes one load or store request from the execute stage, enforces alignment and range checks, steers bytes and strobes into the correct lanes, and sign- or zero-extends load results. Every request completes with a one-cycle `lsu_done`, including requests that are dropped.

## Interface
- MEM_BYTES, 16384: RAM size in bytes; a power of two and a multiple of 4.
- ADDR_WIDTH, $clog2(MEM_BYTES): width of the RAM port address.
- RD_LATENCY, 1: RAM read latency in cycles; legal values are 1 and 2.
- WRITE_FIRST, 0: same-port read-during-write behaviour; 1 returns the new data, 0 returns the old data.

Ports, clock and reset first:
- clk  in  1  clock; all logic updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- mem_valid  in  1  request present; the requester holds all request fields stable until it sees `lsu_done`.
- mem_ren  in  1  load request.
- mem_wen  in  1  store request.
- mem_wstrb  in  4  store size code from `mrv32_pkg`: WSTRB_NONE=0000, WSTRB_B=0001, WSTRB_H=0011, WSTRB_W=1111.
- load_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- eff_addr  in  32  byte address of the access.
- store_data  in  32  store data, right-justified.
- lsu_done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid while `lsu_done` is high.
- a_valid, a_addr[ADDR_WIDTH], a_wdata[32], a_wstrb[4]  in: RAM port A request.
- a_rdata  out  32  RAM port A read data.
- a_rvalid  out  1  RAM port A read-data-valid pulse.

## Operation
RAM (`dual_port_byte_mem`):
- Storage is the array `mem[0:MEM_BYTES-1]`, 8 bits per entry. The bench peeks it hierarchically.
- Each port accepts one access per cycle when `valid` is high. The port address has its low two bits ignored, so every access is word-aligned.
- Any bit set in `wstrb` writes the matching byte lane; lane i is `wdata[8i+7:8i]` and goes to byte address `addr+i` (little-endian).
- Every accepted access returns the little-endian word in `rdata` with a one-cycle `rvalid` pulse, RD_LATENCY cycles later.
- Reads and writes to the same address on different ports in the same cycle: the read returns the old data.
- Both ports write the same byte in the same cycle: port B wins.
- Memory contents are not reset.

LSU (`mrv32_lsu`) state machine, states IDLE, WAIT, DONE, HOLD:
- IDLE with `mem_valid` high: the request is classified.
- A request is legal when all of the following hold:
  - exactly one of `mem_ren` / `mem_wen` is set;
  - `eff_addr < MEM_BYTES`;
  - the address is aligned: halfword accesses need `addr[0]=0`, word accesses need `addr[1:0]=0`;
  - for loads, `load_funct3` is a supported code;
  - for stores, `mem_wstrb` is one of WSTRB_B, WSTRB_H, WSTRB_W.
- Legal load in IDLE:
  - drive `b_valid=1` combinationally, with `b_wstrb=0` and `b_addr=eff_addr[ADDR_WIDTH-1:0]`;
  - move to WAIT.
- Legal store in IDLE:
  - drive `b_valid=1` combinationally;
  - `b_wstrb = mem_wstrb << eff_addr[1:0]`;
  - `b_wdata = store_data << 8*eff_addr[1:0]`;
  - move to DONE.
- Illegal request in IDLE:
  - no port B access;
  - `load_data <= 0`;
  - move to DONE.
- WAIT: on the edge where `b_rvalid=1`, register the extended load result into `load_data` and move to DONE. The lane comes from `eff_addr[1:0]`.
  - LB / LBU: sign- or zero-extend the selected byte.
  - LH / LHU: sign- or zero-extend the selected halfword.
  - LW: pass the whole word through.
- DONE: `lsu_done=1` for exactly one cycle, then move to HOLD.
- HOLD: the request inputs are ignored for one cycle, then the machine returns to IDLE. This keeps a request that is still held after done from being re-issued.
- `load_data` holds its value until the next load completes. A store leaves `load_data` unchanged.

## Timing
- Reset values: state IDLE; `lsu_done=0`; `load_data=0`; `b_valid=0`; `a_rvalid=0`, `b_rvalid=0`; `a_rdata=0`, `b_rdata=0`.
- Legal load, RD_LATENCY=1:
  - request sampled at edge E0;
  - `b_rvalid` is high in cycle E0–E1;
  - `load_data` and `lsu_done` are registered at E1 and high in cycle E1–E2.
- Store or illegal request: the RAM write (if any) commits at E0, and `lsu_done` is high in cycle E0–E1.
- The next request can be accepted two edges after `lsu_done` falls, counting HOLD.
- Reset during WAIT or DONE: the request is abandoned and a late `b_rvalid` is ignored. A write already committed stays in memory.

## Test plan
- SW 0xA1B2C3D4 at 0x100 → `mem[0x100..0x103]` = D4, C3, B2, A1; a following LW returns 0xA1B2C3D4.
- SB 0x80 at 0x101 → LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH 0x8001 at 0x102 → LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW at 0x102 (misaligned) → `lsu_done` pulses, `load_data=0`, `b_valid` never asserts.
- LW at MEM_BYTES+16 → returns 0. SW 0xDEADBEEF at MEM_BYTES+32, then LW at 0x100 → result is not 0xDEADBEEF.
- Hold a request for one cycle after done, then issue a new request in the same timestep → exactly one access per request; `lsu_done` is a single-cycle pulse each time.
